// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART receive path.
//
// Contents:
//   DEF_CLK_FREQ / DEF_UART_BPS : default system clock (Hz) and baud rate
//   DATA_W                      : payload width of one frame (8)
//   rx_state_e                  : receiver FSM state encoding
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit to the
// frame. This adds the ST_PAR state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEF_CLK_FREQ = 50000000;
    localparam int DEF_UART_BPS = 960000;
    localparam int DATA_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PAR,
`endif
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync -- two-flop synchroniser and falling-edge detector for the
// asynchronous serial line.
//
// Ports:
//   sys_clk   in  : system clock
//   sys_rst   in  : asynchronous active-high reset
//   rxd_async in  : raw serial line (idle high)
//   rxd_sync  out : line after the two synchroniser flops
//   fall_edge out : one-cycle pulse on a 1->0 transition of rxd_sync
//
// All flops reset to 1 so that a line that is low when reset releases does
// not look like a start edge.
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic rxd_async,
    output logic rxd_sync,
    output logic fall_edge
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = rxd_async;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rxd_sync  = sync_q;
    assign fall_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8-bit UART receiver (1 start, 8 data LSB first, optional even
// parity, 1 stop).
//
// Parameters:
//   CLK_FREQ : sys_clk frequency in Hz
//   UART_BPS : line baud rate
//
// Ports:
//   sys_clk   in  : system clock
//   sys_rst   in  : asynchronous active-high reset
//   uart_rxd  in  : serial line, idle high
//   uart_data out : last received byte, held between uart_done pulses
//   uart_done out : one-cycle pulse, new byte on uart_data
//   uart_err  out : frame error (bad stop bit / parity), only valid with done
//   rx_busy   out : high whenever a frame is being received
//
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between
// the last data bit and the stop bit.
//
// The baud counter starts at 0 on the start edge and free-runs with period
// BPS_CNT; every bit is sampled where the counter equals MID, i.e. roughly in
// the middle of each bit cell.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int UART_BPS = DEF_UART_BPS
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] uart_data,
    output logic              uart_done,
    output logic              uart_err,
    output logic              rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int MID     = BPS_CNT / 2;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);

    logic rxd_s;
    logic start_edge;

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .rxd_async (uart_rxd),
        .rxd_sync  (rxd_s),
        .fall_edge (start_edge)
    );

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              sample;
    logic              par_err;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    // Even parity: the received parity bit must equal the XOR of the data.
    assign par_err = par_q ^ (^shift_q);
`else
    assign par_err = 1'b0;
`endif

    assign sample = (cnt_q == CNT_MID);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Counter parked at 0 so the first START cycle sees 0.
                cnt_d = '0;
                if (start_edge) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (sample) begin
                    if (rxd_s) begin
                        // Line back high mid start bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end

            ST_DATA: begin
                if (sample) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {rxd_s, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PAR;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PAR: begin
                if (sample) begin
                    par_d   = rxd_s;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (sample) begin
                    data_d  = shift_q;
                    err_d   = ~rxd_s | par_err;
                    done_d  = 1'b1;
                    // Leave mid stop bit so a zero-gap next start edge,
                    // half a bit later, is still seen in IDLE.
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign uart_data = data_q;
    assign uart_done = done_q;
    assign uart_err  = err_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// Frames are serialised bit by bit from a byte value; expected results
// (byte, error flag) are queued per frame and matched against each uart_done.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ = 50000000;
    localparam int UART_BPS = 960000;
    localparam int BPS      = CLK_FREQ / UART_BPS;   // 52 clocks per bit
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       sys_rst;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       uart_err;
    logic       rx_busy;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (sys_rst),
        .uart_rxd  (uart_rxd),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .uart_err  (uart_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int prev_done_cyc = 0;
    int last_done_cyc = 0;
    int err_stray = 0;
    logic done_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every uart_done is one received frame.
    always @(negedge clk) begin
        if (uart_done) begin
            exp_t e;
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (done_prev) err_stray++;
            $display("rx: data=0x%02h err=%0d cycle=%0d", uart_data, uart_err, cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, uart_data}, {24'd0, e.data});
                check("rx_err", {31'd0, uart_err}, {31'd0, e.err});
            end
        end else if (uart_err) begin
            err_stray++;
        end
        done_prev = uart_done;
    end

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (BPS) @(posedge clk);
        #1;
    endtask

    // par: parity bit value on the wire (ignored without parity).
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input int gap_bits);
        exp_t e;
        e.data = d;
        e.err  = ~stop;
`ifdef UART_RX_PARITY_EN
        if (par != ^d) e.err = 1'b1;
`endif
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        for (int g = 0; g < gap_bits; g++) send_bit(1'b1);
    endtask

    initial begin
        int d0;
        logic [7:0] rd;
        logic rs;
        logic rp;
        int rg;

        sys_rst  = 1'b1;
        uart_rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", {24'd0, uart_data}, 32'd0);
        check("rst_done", {31'd0, uart_done}, 32'd0);
        check("rst_err", {31'd0, uart_err}, 32'd0);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        sys_rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Clean frame
        d0 = done_cnt;
        send_frame(8'hA5, 1'b1, ^8'hA5, 1);
        check("clean_done_cnt", done_cnt - d0, 32'd1);
        check("clean_busy", {31'd0, rx_busy}, 32'd0);
        check("clean_hold", {24'd0, uart_data}, 32'hA5);

        // Glitch start
        d0 = done_cnt;
        uart_rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
        uart_rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
        check("glitch_no_done", done_cnt - d0, 32'd0);
        repeat (BPS) @(posedge clk);
        #1;

        // Framing error, then a good byte
        send_frame(8'h3C, 1'b0, ^8'h3C, 1);
        check("ferr_hold", {24'd0, uart_data}, 32'h3C);
        send_frame(8'h55, 1'b1, ^8'h55, 1);

        // Back-to-back, zero idle gap
        send_frame(8'h00, 1'b1, ^8'h00, 0);
        send_frame(8'hFF, 1'b1, ^8'hFF, 1);
        check("b2b_spacing", last_done_cyc - prev_done_cyc, FRAME_BITS * BPS);
        check("b2b_hold", {24'd0, uart_data}, 32'hFF);

        // Reset during bit 4 of 0x81 (bits 0..3 = 1,0,0,0; bit 4 = 0)
        d0 = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        uart_rxd = 1'b0;
        repeat (BPS / 2) @(posedge clk);
        #1;
        sys_rst = 1'b1;
        #1;
        check("midrst_data", {24'd0, uart_data}, 32'd0);
        check("midrst_done", {31'd0, uart_done}, 32'd0);
        check("midrst_err", {31'd0, uart_err}, 32'd0);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        sys_rst  = 1'b0;
        repeat (4 * BPS) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - d0, 32'd0);
        send_frame(8'h81, 1'b1, ^8'h81, 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 1);
        send_frame(8'h01, 1'b1, 1'b0, 1);
`endif

        // Randomised frames
        for (int n = 0; n < 16; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rp = ^rd;
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            rg = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(rd, rs, rp, rg);
        end

        repeat (3 * BPS) @(posedge clk);
        #1;
        check("all_frames_seen", exp_q.size(), 32'd0);
        check("err_or_done_shape", err_stray, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, giving the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter UART_BPS, default 960000, giving the line baud rate.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single system clock; all logic rises on it.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port uart_rxd, input, 1 bit: asynchronous serial line, idle high; it is driven by a uart_tx txd.
REQ-006 The block SHALL have port uart_data, output, 8 bits: the last received byte.
REQ-007 The block SHALL have port uart_done, output, 1 bit: a one-cycle pulse marking a new byte on uart_data.
REQ-008 The block SHALL have port uart_err, output, 1 bit: a frame error flag, valid only while uart_done is high.
REQ-009 The block SHALL have port rx_busy, output, 1 bit: high while a frame is in progress.

Function
REQ-010 BPS_CNT SHALL be CLK_FREQ/UART_BPS, integer truncated; MID SHALL be BPS_CNT/2, truncated.
REQ-011 uart_rxd SHALL pass through a 2-flop synchroniser (reset value 1) before any use; the start edge SHALL be a 1->0 transition of the synchronised line.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PAR (present only with the macro), and STOP.
REQ-013 In IDLE, a start edge SHALL move the FSM to START and clear the baud counter.
REQ-014 The baud counter SHALL count 0..BPS_CNT-1 and wrap to 0; the sample point SHALL be the cycle where the counter equals MID.
REQ-015 START, at the sample point: if the line is high (glitch), the FSM SHALL return to IDLE with no uart_done; otherwise it SHALL go to DATA with the bit index at 0.
REQ-016 DATA SHALL sample 8 bits LSB first, one per sample point, into a shift register; after bit 7 it SHALL go to PAR if the macro is enabled, else to STOP.
REQ-017 STOP, at the sample point, SHALL:
- load uart_data from the shift register;
- set uart_err = (stop bit == 0) OR parity error;
- pulse uart_done high for exactly 1 cycle, on the cycle after the sample point;
- return to IDLE immediately, so that a start edge arriving half a bit later is caught (back-to-back frames with zero idle gap).
REQ-018 uart_data SHALL hold its value between uart_done pulses, including frames with an error.
REQ-019 uart_err SHALL be 0 whenever uart_done is 0.
REQ-020 rx_busy SHALL be high in every state except IDLE.
REQ-021 Start edges arriving outside IDLE SHALL be ignored.

Reset
REQ-022 Asserting sys_rst at any time, including mid-frame, SHALL force: FSM to IDLE, counters and shift register to 0, synchroniser flops to 1, uart_data to 0x00, and uart_done, uart_err and rx_busy to 0.
REQ-023 A frame in progress when reset is asserted SHALL be discarded with no uart_done.

Configuration
REQ-024 With macro UART_RX_PARITY_EN defined, the frame SHALL be 1 start + 8 data + 1 even-parity + 1 stop bit; PAR samples the parity bit at its sample point, and a mismatch against the XOR of the data bits SHALL set uart_err.
REQ-025 Without UART_RX_PARITY_EN, the frame SHALL be 1 start + 8 data + 1 stop bit, the PAR state SHALL not exist, and uart_err SHALL reflect the stop bit only.

Structure
REQ-026 Shared package uart_pkg SHALL hold:
- the FSM state typedef;
- default CLK_FREQ and UART_BPS constants;
- the data-width constant (8).
REQ-027 Synchroniser plus falling-edge detect SHALL be sub-module uart_rx_sync; baud counter and FSM stay in uart_rx.

Verification (CLK_FREQ=50000000, UART_BPS=960000: BPS_CNT=52, MID=26; no macro unless stated)
REQ-028 Clean frame: send 0xA5, 52 clocks per bit -> exactly one uart_done, uart_data=0xA5, uart_err=0, rx_busy low after the pulse.
REQ-029 Glitch start: hold uart_rxd low for 10 cycles, then high -> no uart_done, rx_busy returns to 0 by about cycle 30.
REQ-030 Framing error: send 0x3C with stop bit low -> uart_done with uart_err=1, uart_data=0x3C; a following valid 0x55 is received with uart_err=0.
REQ-031 Back-to-back: 0x00 then 0xFF with no idle gap -> two uart_done pulses about 520 cycles apart, with data 0x00 then 0xFF.
REQ-032 Reset mid-frame: assert sys_rst during bit 4 of 0x81 -> all outputs 0 immediately and no uart_done for that frame; the next 0x81 is received correctly.
REQ-033 With UART_RX_PARITY_EN: 0x01 with parity bit 1 -> uart_err=0; 0x01 with parity bit 0 -> uart_err=1.
